// File: rtl/vm_credit_engine_pkg.sv
// vm_credit_engine_pkg: shared state encodings and coin index constants
package vm_credit_engine_pkg;
  localparam int K_TOTAL_BITS = 31;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RETURN} state_t;
  localparam logic [1:0] COIN_IDX_LO  = 2'd0;
  localparam logic [1:0] COIN_IDX_MID = 2'd1;
  localparam logic [1:0] COIN_IDX_HI  = 2'd2;
endpackage

// File: rtl/vm_credit_engine_wait_timer.sv
// vm_wait_timer: inactivity timeout with reload, clear, hold and saturating countdown
module vm_wait_timer #(
  parameter int WAIT_BITS  = 32,
  parameter int WAIT_LIMIT = 100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reload,
  input  logic                 hold,
  input  logic                 clear,
  output logic [WAIT_BITS-1:0] wait_time
);
  // clear wins over reload so leaving ACTIVE always parks the timer at zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wait_time <= '0;
    else if (clear) wait_time <= '0;
    else if (reload) wait_time <= WAIT_BITS'(WAIT_LIMIT);
    else if (!hold && wait_time != '0) wait_time <= wait_time - WAIT_BITS'(1);
endmodule

// File: rtl/vm_credit_engine.sv
// vm_credit_engine: credit register, purchase arbitration and greedy change return
module vm_credit_engine
  import vm_credit_engine_pkg::*;
#(
  parameter int TOTAL_BITS = K_TOTAL_BITS,
  parameter int WAIT_BITS  = 32,
  parameter int WAIT_LIMIT = 100,
  parameter int COIN_HI    = 1000,
  parameter int COIN_MID   = 500,
  parameter int COIN_LO    = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ins_valid,
  input  logic [TOTAL_BITS-1:0] ins_value,
  input  logic                  sel_valid,
  input  logic [TOTAL_BITS-1:0] sel_price,
  input  logic                  ret_req,
  input  logic                  coin_ready,
  output logic                  ins_reject,
  output logic                  sel_accept,
  output logic                  sel_reject,
  output logic                  coin_valid,
  output logic [1:0]            coin_idx,
  output logic                  ret_done,
  output logic                  busy,
  output logic [TOTAL_BITS-1:0] current_total,
  output logic [WAIT_BITS-1:0]  wait_time
);
  localparam logic [TOTAL_BITS-1:0] C_HI  = TOTAL_BITS'(COIN_HI);
  localparam logic [TOTAL_BITS-1:0] C_MID = TOTAL_BITS'(COIN_MID);
  localparam logic [TOTAL_BITS-1:0] C_LO  = TOTAL_BITS'(COIN_LO);
  state_t state, state_nx;
  logic [TOTAL_BITS:0] sum;
  logic [TOTAL_BITS-1:0] t, total_nx, coin_val;
  logic carry, ins_acc, sel_ok;
  logic ins_rej_nx, sel_acc_nx, sel_rej_nx, done_nx;
  logic reload, hold, clear;
  assign sum        = {1'b0, current_total} + {1'b0, ins_value};
  assign carry      = sum[TOTAL_BITS];
  assign ins_acc    = ins_valid && !carry;
  assign t          = ins_acc ? sum[TOTAL_BITS-1:0] : current_total;
  assign sel_ok     = t >= sel_price;
  assign busy       = state == ST_RETURN;
  assign coin_valid = busy && current_total >= C_LO;
  assign coin_idx   = current_total >= C_HI ? COIN_IDX_HI : current_total >= C_MID ? COIN_IDX_MID : COIN_IDX_LO;
  assign coin_val   = coin_idx == COIN_IDX_HI ? C_HI : coin_idx == COIN_IDX_MID ? C_MID : C_LO;
  vm_wait_timer #(.WAIT_BITS(WAIT_BITS), .WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk(clk), .reset_n(reset_n), .reload(reload), .hold(hold), .clear(clear), .wait_time(wait_time)
  );
  // next state, next credit and pulse requests; ret_req in ACTIVE pre-empts insert/select
  always_comb begin
    state_nx   = state;
    total_nx   = current_total;
    ins_rej_nx = 1'b0;
    sel_acc_nx = 1'b0;
    sel_rej_nx = 1'b0;
    done_nx    = 1'b0;
    reload     = 1'b0;
    hold       = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        hold       = 1'b1;
        ins_rej_nx = ins_valid && carry;
        sel_rej_nx = sel_valid;
        if (ins_acc) begin
          total_nx = ins_value;
          reload   = 1'b1;
          state_nx = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ret_req) begin
          ins_rej_nx = ins_valid;
          sel_rej_nx = sel_valid;
          clear      = 1'b1;
          state_nx   = ST_RETURN;
        end else begin
          ins_rej_nx = ins_valid && carry;
          sel_acc_nx = sel_valid && sel_ok;
          sel_rej_nx = sel_valid && !sel_ok;
          total_nx   = sel_acc_nx ? t - sel_price : t;
          reload     = ins_acc || sel_acc_nx;
          if (sel_acc_nx && total_nx == '0) begin
            clear    = 1'b1;
            state_nx = ST_IDLE;
          end else if (!reload && wait_time == '0) state_nx = ST_RETURN;
        end
      end
      default: begin
        clear      = 1'b1;
        ins_rej_nx = ins_valid;
        sel_rej_nx = sel_valid;
        if (!coin_valid) begin
          total_nx = '0;
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end else if (coin_ready) total_nx = current_total - coin_val;
      end
    endcase
  end
  // state, credit and one-cycle event pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= ST_IDLE;
      current_total <= '0;
      ins_reject    <= 1'b0;
      sel_accept    <= 1'b0;
      sel_reject    <= 1'b0;
      ret_done      <= 1'b0;
    end else begin
      state         <= state_nx;
      current_total <= total_nx;
      ins_reject    <= ins_rej_nx;
      sel_accept    <= sel_acc_nx;
      sel_reject    <= sel_rej_nx;
      ret_done      <= done_nx;
    end
endmodule

// File: tb/tb_vm_credit_engine.sv
// tb_vm_credit_engine: directed checks with a coin-order scoreboard
module tb_vm_credit_engine;
  localparam int TB = 11;
  localparam int WB = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic ins_valid = 1'b0, sel_valid = 1'b0, ret_req = 1'b0, coin_ready = 1'b0;
  logic [TB-1:0] ins_value = '0, sel_price = '0;
  logic ins_reject, sel_accept, sel_reject, coin_valid, ret_done, busy;
  logic [1:0] coin_idx;
  logic [TB-1:0] current_total;
  logic [WB-1:0] wait_time;
  logic [1:0] exp_q[$];
  logic [1:0] exp_idx;
  int checks = 0, errors = 0;

  vm_credit_engine #(.TOTAL_BITS(TB), .WAIT_BITS(WB), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .ins_valid(ins_valid), .ins_value(ins_value),
    .sel_valid(sel_valid), .sel_price(sel_price), .ret_req(ret_req), .coin_ready(coin_ready),
    .ins_reject(ins_reject), .sel_accept(sel_accept), .sel_reject(sel_reject),
    .coin_valid(coin_valid), .coin_idx(coin_idx), .ret_done(ret_done), .busy(busy),
    .current_total(current_total), .wait_time(wait_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && coin_valid && coin_ready) begin
      if (exp_q.size() == 0) chk("coin_extra", 32'(coin_idx), 32'd3);
      else begin
        exp_idx = exp_q.pop_front();
        chk("coin_idx", 32'(coin_idx), 32'(exp_idx));
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int v);
    ins_valid = 1'b1;
    ins_value = TB'(v);
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic ret();
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n = 0;
    while (!ret_done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_total"}, current_total, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_queue"}, exp_q.size(), 0);
    coin_ready = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, ret_done, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("rst_total", current_total, 0);
    chk("rst_wait", wait_time, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_pulses", {ins_reject, sel_accept, sel_reject, ret_done}, 0);
    // basic purchase then timeout
    ins(1000);
    chk("t1_total", current_total, 1000);
    chk("t1_wait", wait_time, 4);
    sel_valid = 1'b1; sel_price = TB'(700);
    tick();
    sel_valid = 1'b0;
    chk("t1_sel_accept", sel_accept, 1);
    chk("t1_total_after", current_total, 300);
    chk("t1_wait_reload", wait_time, 4);
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk("t1_countdown", wait_time, i);
      chk("t1_not_busy", busy, 0);
    end
    chk("t1_pulse_cleared", sel_accept, 0);
    coin_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    tick();
    chk("t1_timeout_return", busy, 1);
    wait_done("t1", 4);
    // greedy return under backpressure
    ins(1000);
    ins(600);
    chk("t2_total", current_total, 1600);
    ret();
    chk("t2_busy", busy, 1);
    chk("t2_wait_zero", wait_time, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", coin_valid, 1);
      chk("t2_hold_idx", coin_idx, 2);
      chk("t2_hold_total", current_total, 1600);
      tick();
    end
    exp_q.push_back(2'd2); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    coin_ready = 1'b1;
    wait_done("t2", 4);
    // simultaneous insert + select, then insert + return
    ins(300);
    ins_valid = 1'b1; ins_value = TB'(500); sel_valid = 1'b1; sel_price = TB'(800);
    tick();
    ins_valid = 1'b0; sel_valid = 1'b0;
    chk("t3_sel_accept", sel_accept, 1);
    chk("t3_total", current_total, 0);
    chk("t3_wait", wait_time, 0);
    chk("t3_idle", busy, 0);
    ins(300);
    ins_valid = 1'b1; ins_value = TB'(500); ret_req = 1'b1;
    tick();
    ins_valid = 1'b0; ret_req = 1'b0;
    chk("t3_ins_reject", ins_reject, 1);
    chk("t3_busy", busy, 1);
    chk("t3_total_kept", current_total, 300);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    coin_ready = 1'b1;
    wait_done("t3", 4);
    // refusals
    sel_valid = 1'b1; sel_price = TB'(100);
    tick();
    sel_valid = 1'b0;
    chk("t4_idle_sel_reject", sel_reject, 1);
    chk("t4_idle_total", current_total, 0);
    ins(1000);
    ret();
    ins(500);
    chk("t4_ret_ins_reject", ins_reject, 1);
    chk("t4_ret_total", current_total, 1000);
    exp_q.push_back(2'd2);
    coin_ready = 1'b1;
    wait_done("t4", 2);
    ins(1000);
    ins(1000);
    ins(100);
    chk("t4_carry_reject", ins_reject, 1);
    chk("t4_carry_total", current_total, 2000);
    ret();
    exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    coin_ready = 1'b1;
    wait_done("t4c", 3);
    // residual below the smallest coin is discarded
    ins(150);
    ret();
    exp_q.push_back(2'd0);
    coin_ready = 1'b1;
    wait_done("t5", 2);
    // asynchronous reset in the middle of a return
    ins(1000);
    ret();
    chk("t6_coin_valid", coin_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_coin_valid", coin_valid, 0);
    chk("t6_rst_total", current_total, 0);
    chk("t6_rst_busy", busy, 0);
    #3 reset_n = 1'b1;
    tick();
    chk("t6_post_busy", busy, 0);
    chk("t6_post_wait", wait_time, 0);
    chk("t6_post_total", current_total, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
